fetch_stage_ras: RTL and testbench
==================================

Name: fetch_stage_ras

Overview:
Parametrised instruction-fetch stage. It holds the PC register and selects the next PC among sequential, relative branch, absolute jump, call and return. It contains an internal return-address stack (RAS) of configurable depth, replacing the external stack input. It drives a synchronous-read instruction memory and sits at the head of the pipeline, feeding the decode stage.

Parameters:
PC_W, 12, PC / address width in bits
INSTR_W, 19, instruction word width
RAS_DEPTH, 8, return-stack entries; power of two, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
pcEnb  in  1  1 = advance the PC; 0 = stall (hold all state)
branchTaken  in  1  relative branch: next PC = pcOut + disp
disp  in  PC_W  two's-complement branch displacement
jumpEn  in  1  absolute jump to jumpAdr
callEn  in  1  call: push pcOut+1, next PC = jumpAdr
retEn  in  1  return: pop the RAS top, next PC = popped value
jumpAdr  in  PC_W  jump/call target
imemAddr  out  PC_W  address to the synchronous-read instruction memory
imemData  in  INSTR_W  memory read data, one cycle after imemAddr
pcOut  out  PC_W  PC of the current instruction
instruction  out  INSTR_W  instruction at pcOut (equals imemData)
instrValid  out  1  instruction corresponds to pcOut
rasCount  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries
rasOverflow  out  1  sticky: a push occurred while the RAS was full
rasUnderflow  out  1  sticky: a pop occurred while the RAS was empty

Behaviour:
- Reset (rst=1 at a clock edge):
  - pcOut=RESET_PC, rasCount=0, RAS pointer=0.
  - rasOverflow=0, rasUnderflow=0, instrValid=0.
  - RAS contents are don't-care.
- During reset, imemAddr=RESET_PC. The first post-reset cycle therefore presents mem[RESET_PC], and instrValid=1 from that cycle.
- Next-PC (pcIn) priority, all arithmetic modulo 2^PC_W:
  - retEn: next PC = RAS top.
  - else callEn: next PC = jumpAdr.
  - else jumpEn: next PC = jumpAdr.
  - else branchTaken: next PC = pcOut+disp.
  - else: next PC = pcOut+1.
- retEn and callEn in the same cycle: next PC = jumpAdr, and the top entry is overwritten with pcOut+1. rasCount is unchanged. If the RAS is empty, this acts as a plain push and rasUnderflow is not set.
- Push when full (rasCount=RAS_DEPTH): the circular pointer wraps and overwrites the oldest entry. rasCount stays at RAS_DEPTH and rasOverflow is set.
- Pop when empty: next PC = pcOut+1, the pointer is unchanged and rasUnderflow is set.
- imemAddr = rst ? RESET_PC : (pcEnb ? pcIn : pcOut). The memory output is thus always aligned with pcOut. A stall re-reads the same address and instrValid stays 1.
- pcEnb=0: pcOut, the RAS and the flags hold. All control inputs are ignored.
- No FSM beyond reset/run. instrValid is a registered ~rst.
- Reset asserted mid-call/return wins over everything.

Optional Feature:
FETCH_STATS_EN.
- Defined: adds outputs fetchCount[15:0] and stallCount[15:0], both cleared by rst.
  - fetchCount increments each cycle with pcEnb=1 and instrValid=1.
  - stallCount increments each cycle with pcEnb=0 and instrValid=1.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package fetch_pkg: localparam RAS_PTR_W function ($clog2), next-PC select encoding (SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET), default widths.
- One sub-module: return_stack (parametrised circular LIFO with push/pop/replace, count, and sticky overflow/underflow flags).
- The top level holds the PC register, the next-PC mux and the memory address logic.

Test Plan:
- Reset then 4 cycles of pcEnb=1 -> pcOut 0,1,2,3,4; imemAddr leads pcOut by one; instrValid=1 from the first post-reset cycle.
- At PC=5, branchTaken with disp=12'hFFE -> next PC=3. At PC=0, branchTaken with disp=12'h005 -> next PC=5. At PC=12'hFFF sequential -> next PC=0 (wrap).
- At PC=10, callEn with jumpAdr=100; run to 102; retEn -> PC 100,101,102,11; rasCount goes 1 then 0.
- RAS_DEPTH=4: issue 5 calls at PCs 1,11,21,31,41 -> rasOverflow=1, rasCount=4. Four returns yield 42,32,22,12. A fifth return gives next PC=pcOut+1 and rasUnderflow=1.
- retEn and callEn together at PC=50 with jumpAdr=200 and top=7 -> next PC=200, top=51, rasCount unchanged.
- pcEnb=0 for 3 cycles during callEn -> pcOut, rasCount and imemAddr hold; instrValid=1. With FETCH_STATS_EN: stallCount=3.

Source files
------------

// File: rtl/fetch_stage_ras_pkg.sv
// Shared definitions for the fetch stage: default widths, RAS pointer width
// helper and the next-PC select encoding.
package fetch_pkg;

   localparam int DEF_PC_W      = 12;
   localparam int DEF_INSTR_W   = 19;
   localparam int DEF_RAS_DEPTH = 8;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JMP,
      SEL_CALL,
      SEL_RET
   } pc_sel_e;

   function automatic int ras_ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_stage_ras_return_stack.sv
// Circular return-address LIFO with push, pop and replace-top, a valid-entry
// count and sticky overflow/underflow flags.
module return_stack
   import fetch_pkg::*;
#(
   parameter int W     = DEF_PC_W,
   parameter int DEPTH = DEF_RAS_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      replace,
   input  logic [W-1:0]              wdata,
   output logic [W-1:0]              top,
   output logic                      empty,
   output logic [ras_ptr_w(DEPTH):0] count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PTR_W = ras_ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] wr_idx;
   logic             full;
   logic             advance;
   logic             do_write;

   assign top_idx = ptr - PTR_W'(1);
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign top     = mem[top_idx];

   // Replace on an empty stack degenerates into a plain push.
   assign advance  = push | (replace & empty);
   assign do_write = push | replace;
   assign wr_idx   = (replace && !empty) ? top_idx : ptr;

   always_ff @(posedge clk) begin
      if (!rst && do_write) begin
         mem[wr_idx] <= wdata;
      end
   end

   // A full push wraps the pointer onto the oldest entry; count saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (advance) begin
         ptr <= ptr + PTR_W'(1);
         if (full) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end else if (pop) begin
         if (empty) begin
            underflow <= 1'b1;
         end else begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_stage_ras.sv
// Instruction-fetch stage: PC register, next-PC select and internal return stack.
// Optional macro FETCH_STATS_EN adds saturating fetchCount/stallCount outputs.
module fetch_stage_ras
   import fetch_pkg::*;
#(
   parameter int              PC_W      = DEF_PC_W,
   parameter int              INSTR_W   = DEF_INSTR_W,
   parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pcEnb,
   input  logic                          branchTaken,
   input  logic [PC_W-1:0]               disp,
   input  logic                          jumpEn,
   input  logic                          callEn,
   input  logic                          retEn,
   input  logic [PC_W-1:0]               jumpAdr,
   output logic [PC_W-1:0]               imemAddr,
   input  logic [INSTR_W-1:0]            imemData,
   output logic [PC_W-1:0]               pcOut,
   output logic [INSTR_W-1:0]            instruction,
   output logic                          instrValid,
   output logic [ras_ptr_w(RAS_DEPTH):0] rasCount,
   output logic                          rasOverflow,
   output logic                          rasUnderflow
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0]                   fetchCount,
   output logic [15:0]                   stallCount
`endif
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_in;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] ras_top;
   logic            ras_empty;
   logic            ras_push;
   logic            ras_pop;
   logic            ras_replace;
   pc_sel_e         sel;

   assign pc_inc = pc + PC_W'(1);

   // A lone return with nothing on the stack falls through sequentially.
   always_comb begin
      sel = SEL_SEQ;
      if (retEn && !callEn) begin
         sel = ras_empty ? SEL_SEQ : SEL_RET;
      end else if (callEn) begin
         sel = SEL_CALL;
      end else if (jumpEn) begin
         sel = SEL_JMP;
      end else if (branchTaken) begin
         sel = SEL_BR;
      end
   end

   always_comb begin
      pc_in = pc_inc;
      case (sel)
         SEL_RET:  pc_in = ras_top;
         SEL_CALL: pc_in = jumpAdr;
         SEL_JMP:  pc_in = jumpAdr;
         SEL_BR:   pc_in = pc + disp;
         default:  pc_in = pc_inc;
      endcase
   end

   assign ras_push    = pcEnb & callEn & ~retEn;
   assign ras_replace = pcEnb & callEn & retEn;
   assign ras_pop     = pcEnb & retEn & ~callEn;

   return_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (ras_push),
      .pop       (ras_pop),
      .replace   (ras_replace),
      .wdata     (pc_inc),
      .top       (ras_top),
      .empty     (ras_empty),
      .count     (rasCount),
      .overflow  (rasOverflow),
      .underflow (rasUnderflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (pcEnb) begin
         pc <= pc_in;
      end
   end

   always_ff @(posedge clk) begin
      instrValid <= ~rst;
   end

   // Addressing the next PC keeps the synchronous memory output aligned with pcOut.
   assign imemAddr    = rst ? RESET_PC : (pcEnb ? pc_in : pc);
   assign pcOut       = pc;
   assign instruction = imemData;

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetchCount <= '0;
         stallCount <= '0;
      end else if (instrValid) begin
         if (pcEnb && fetchCount != 16'hFFFF) begin
            fetchCount <= fetchCount + 16'd1;
         end
         if (!pcEnb && stallCount != 16'hFFFF) begin
            stallCount <= stallCount + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage_ras.sv
// Testbench for fetch_stage_ras: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_stage_ras;

   localparam int PC_W    = 12;
   localparam int INSTR_W = 19;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 3;
   localparam logic [PC_W-1:0] RST_PC = 12'h000;

   logic               clk;
   logic               rst;
   logic               pcEnb;
   logic               branchTaken;
   logic [PC_W-1:0]    disp;
   logic               jumpEn;
   logic               callEn;
   logic               retEn;
   logic [PC_W-1:0]    jumpAdr;
   logic [PC_W-1:0]    imemAddr;
   logic [INSTR_W-1:0] imemData;
   logic [PC_W-1:0]    pcOut;
   logic [INSTR_W-1:0] instruction;
   logic               instrValid;
   logic [CNT_W-1:0]   rasCount;
   logic               rasOverflow;
   logic               rasUnderflow;

   fetch_stage_ras #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .RAS_DEPTH (DEPTH),
      .RESET_PC  (RST_PC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pcEnb        (pcEnb),
      .branchTaken  (branchTaken),
      .disp         (disp),
      .jumpEn       (jumpEn),
      .callEn       (callEn),
      .retEn        (retEn),
      .jumpAdr      (jumpAdr),
      .imemAddr     (imemAddr),
      .imemData     (imemData),
      .pcOut        (pcOut),
      .instruction  (instruction),
      .instrValid   (instrValid),
      .rasCount     (rasCount),
      .rasOverflow  (rasOverflow),
      .rasUnderflow (rasUnderflow)
   );

   // ---------------- clock / memory ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [INSTR_W-1:0] mem_f(input logic [PC_W-1:0] a);
      return {a[6:0], a} ^ 19'h2A5C3;
   endfunction

   always @(posedge clk) imemData <= mem_f(imemAddr);

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [PC_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [PC_W-1:0] m_pc    = '0;
   logic [PC_W-1:0] m_ras[$];
   logic            m_ovf   = 1'b0;
   logic            m_unf   = 1'b0;
   logic            m_valid = 1'b0;

   function automatic logic [PC_W-1:0] model_next(input logic r, input logic enb, input logic br,
                                                   input logic [PC_W-1:0] d, input logic jmp,
                                                   input logic call, input logic ret,
                                                   input logic [PC_W-1:0] adr);
      logic [PC_W-1:0] seq;
      seq = m_pc + 12'd1;
      if (r) return RST_PC;
      if (!enb) return m_pc;
      if (ret && call) return adr;
      if (ret) return (m_ras.size() == 0) ? seq : m_ras[m_ras.size()-1];
      if (call || jmp) return adr;
      if (br) return m_pc + d;
      return seq;
   endfunction

   task automatic model_update(input logic r, input logic enb, input logic br,
                               input logic [PC_W-1:0] d, input logic jmp,
                               input logic call, input logic ret, input logic [PC_W-1:0] adr);
      logic [PC_W-1:0] nxt;
      logic [PC_W-1:0] seq;
      nxt = model_next(r, enb, br, d, jmp, call, ret, adr);
      seq = m_pc + 12'd1;
      if (r) begin
         m_pc = RST_PC;
         m_ras.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_valid = 1'b0;
      end else begin
         m_valid = 1'b1;
         if (enb) begin
            if (ret && call) begin
               if (m_ras.size() == 0) m_ras.push_back(seq);
               else m_ras[m_ras.size()-1] = seq;
            end else if (ret) begin
               if (m_ras.size() == 0) m_unf = 1'b1;
               else void'(m_ras.pop_back());
            end else if (call) begin
               if (m_ras.size() == DEPTH) begin
                  m_ovf = 1'b1;
                  void'(m_ras.pop_front());
               end
               m_ras.push_back(seq);
            end
            m_pc = nxt;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick(input logic r, input logic enb, input logic br, input logic [PC_W-1:0] d,
                       input logic jmp, input logic call, input logic ret,
                       input logic [PC_W-1:0] adr);
      rst = r; pcEnb = enb; branchTaken = br; disp = d;
      jumpEn = jmp; callEn = call; retEn = ret; jumpAdr = adr;
      #1;
      check("imem_addr", 32'(imemAddr), 32'(model_next(r, enb, br, d, jmp, call, ret, adr)));
      model_update(r, enb, br, d, jmp, call, ret, adr);
      exp_q.push_back(m_pc);
      @(posedge clk);
      #1;
      check("pc_out", 32'(pcOut), 32'(exp_q.pop_front()));
      check("ras_count", 32'(rasCount), 32'(m_ras.size()));
      check("ras_overflow", 32'(rasOverflow), 32'(m_ovf));
      check("ras_underflow", 32'(rasUnderflow), 32'(m_unf));
      check("instr_valid", 32'(instrValid), 32'(m_valid));
      if (m_valid) check("instruction", 32'(instruction), 32'(mem_f(m_pc)));
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic            r;
      logic            enb;
      logic            br;
      logic [PC_W-1:0] d;
      logic            jmp;
      logic            call;
      logic            ret;
      logic [PC_W-1:0] adr;
      logic [PC_W-1:0] exp_pc;
      int              exp_cnt;
      logic            exp_ovf;
      logic            exp_unf;
   } vec_t;

   vec_t vecs[$];

   task automatic add_v(input logic r, input logic enb, input logic br, input logic [PC_W-1:0] d,
                        input logic jmp, input logic call, input logic ret,
                        input logic [PC_W-1:0] adr, input logic [PC_W-1:0] epc,
                        input int ecnt, input logic eovf, input logic eunf);
      vecs.push_back('{r, enb, br, d, jmp, call, ret, adr, epc, ecnt, eovf, eunf});
   endtask

   initial begin
      // reset, then sequential fetch and branch/wrap cases
      add_v(1,1,0,12'h000,0,0,0,12'd0,   12'd0,   0,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd1,   0,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd2,   0,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd3,   0,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd4,   0,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd5,   0,0,0);
      add_v(0,1,1,12'hFFE,0,0,0,12'd0,   12'd3,   0,0,0);
      add_v(0,1,0,12'h000,1,0,0,12'd0,   12'd0,   0,0,0);
      add_v(0,1,1,12'h005,0,0,0,12'd0,   12'd5,   0,0,0);
      add_v(0,1,0,12'h000,1,0,0,12'hFFF, 12'hFFF, 0,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd0,   0,0,0);
      // call / return
      add_v(0,1,0,12'h000,1,0,0,12'd10,  12'd10,  0,0,0);
      add_v(0,1,0,12'h000,0,1,0,12'd100, 12'd100, 1,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd101, 1,0,0);
      add_v(0,1,0,12'h000,0,0,0,12'd0,   12'd102, 1,0,0);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd11,  0,0,0);
      // overflow on the fifth call, then drain and underflow
      add_v(0,1,0,12'h000,1,0,0,12'd1,   12'd1,   0,0,0);
      add_v(0,1,0,12'h000,0,1,0,12'd11,  12'd11,  1,0,0);
      add_v(0,1,0,12'h000,0,1,0,12'd21,  12'd21,  2,0,0);
      add_v(0,1,0,12'h000,0,1,0,12'd31,  12'd31,  3,0,0);
      add_v(0,1,0,12'h000,0,1,0,12'd41,  12'd41,  4,0,0);
      add_v(0,1,0,12'h000,0,1,0,12'd50,  12'd50,  4,1,0);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd42,  3,1,0);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd32,  2,1,0);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd22,  1,1,0);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd12,  0,1,0);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd13,  0,1,1);
      // simultaneous return + call replaces the top
      add_v(0,1,0,12'h000,1,0,0,12'd6,   12'd6,   0,1,1);
      add_v(0,1,0,12'h000,0,1,0,12'd50,  12'd50,  1,1,1);
      add_v(0,1,0,12'h000,0,1,1,12'd200, 12'd200, 1,1,1);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd51,  0,1,1);
      // stall during a call holds everything
      add_v(0,1,0,12'h000,1,0,0,12'd60,  12'd60,  0,1,1);
      add_v(0,0,0,12'h000,0,1,0,12'd300, 12'd60,  0,1,1);
      add_v(0,0,0,12'h000,0,1,0,12'd300, 12'd60,  0,1,1);
      add_v(0,0,0,12'h000,0,1,0,12'd300, 12'd60,  0,1,1);
      add_v(0,1,0,12'h000,0,1,0,12'd300, 12'd300, 1,1,1);
      add_v(0,1,0,12'h000,0,0,1,12'd0,   12'd61,  0,1,1);

      foreach (vecs[i]) begin
         tick(vecs[i].r, vecs[i].enb, vecs[i].br, vecs[i].d, vecs[i].jmp,
              vecs[i].call, vecs[i].ret, vecs[i].adr);
         check("tbl_pc", 32'(pcOut), 32'(vecs[i].exp_pc));
         check("tbl_count", 32'(rasCount), 32'(vecs[i].exp_cnt));
         check("tbl_overflow", 32'(rasOverflow), 32'(vecs[i].exp_ovf));
         check("tbl_underflow", 32'(rasUnderflow), 32'(vecs[i].exp_unf));
         if (i == 0) check("tbl_valid_in_reset", 32'(instrValid), 32'd0);
         if (i == 1) check("tbl_valid_first", 32'(instrValid), 32'd1);
         if (vecs[i].enb == 1'b0) check("tbl_stall_valid", 32'(instrValid), 32'd1);
      end

      // reset asserted mid-call wins over everything
      tick(1,1,0,12'h000,0,1,0,12'd77);
      check("rst_mid_call_pc", 32'(pcOut), 32'(RST_PC));
      check("rst_mid_call_count", 32'(rasCount), 32'd0);
      check("rst_mid_call_ovf", 32'(rasOverflow), 32'd0);
      check("rst_mid_call_unf", 32'(rasUnderflow), 32'd0);
      check("rst_mid_call_valid", 32'(instrValid), 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         tick(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 3) == 0),
              12'($urandom_range(0, 4095)),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0),
              12'($urandom_range(0, 4095)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // watchdog: the stimulus is purely cycle-counted, so this only trips on a runaway bench
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

endmodule
